// File: rtl/wiper_motor_seq.sv
// Wiper motor sequencer: runs complete park -> far end -> park sweeps from the
// wipe request, with intermittent dwell, per-half timeout and sensor-contradiction faults.
module wiper_motor_seq #(
  parameter int TIMEOUT   = 1000,
  parameter int INT_DELAY = 500,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wipe_req,
  input  logic [1:0]       mode,
  input  logic             park_sw,
  input  logic             end_sw,
  output logic             motor_fwd,
  output logic             motor_rev,
  output logic             fast,
  output logic             busy,
  output logic [CNT_W-1:0] sweep_cnt,
  output logic             fault
);

  typedef enum logic [2:0] {PARK, OUT, BACK, DWELL, FAULT} state_t;

  localparam int TMAX = (TIMEOUT > INT_DELAY) ? TIMEOUT : INT_DELAY;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    DWELL_LAST   = TW'(INT_DELAY - 1);
  localparam logic [TW-1:0]    TIMER_ONE    = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    mode_q;
  logic          repark;

  // Output pattern {motor_fwd, motor_rev, fast, busy} for the state being entered
  function automatic logic [3:0] drive(state_t s, logic hi);
    case (s)
      OUT:     drive = {1'b1, 1'b0, hi, 1'b1};
      BACK:    drive = {1'b0, 1'b1, hi, 1'b1};
      DWELL:   drive = 4'b0001;
      default: drive = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PARK;
      timer     <= '0;
      mode_q    <= 2'b01;
      repark    <= 1'b0;
      {motor_fwd, motor_rev, fast, busy} <= 4'b0000;
      sweep_cnt <= '0;
      fault     <= 1'b0;
    end else if (state != FAULT && park_sw && end_sw) begin
      state <= FAULT;
      timer <= '0;
      {motor_fwd, motor_rev, fast, busy} <= 4'b0000;
      fault <= 1'b1;
    end else begin
      case (state)
        PARK: begin
          if (wipe_req) begin
            timer <= '0;
            if (park_sw) begin
              state  <= OUT;
              mode_q <= mode;
              repark <= 1'b0;
              {motor_fwd, motor_rev, fast, busy} <= drive(OUT, mode[1]);
            end else begin
              // Arm stranded off park: bring it home without counting a sweep
              state  <= BACK;
              repark <= 1'b1;
              {motor_fwd, motor_rev, fast, busy} <= drive(BACK, mode_q[1]);
            end
          end
        end
        OUT: begin
          if (end_sw) begin
            state <= BACK;
            timer <= '0;
            {motor_fwd, motor_rev, fast, busy} <= drive(BACK, mode_q[1]);
          end else if (timer == TIMEOUT_LAST) begin
            state <= FAULT;
            timer <= '0;
            {motor_fwd, motor_rev, fast, busy} <= 4'b0000;
            fault <= 1'b1;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        BACK: begin
          if (park_sw) begin
            timer  <= '0;
            repark <= 1'b0;
            if (!repark)
              sweep_cnt <= sweep_cnt + CNT_ONE;
            if (mode_q == 2'b00 && wipe_req) begin
              state <= DWELL;
              {motor_fwd, motor_rev, fast, busy} <= drive(DWELL, mode_q[1]);
            end else begin
              state <= PARK;
              {motor_fwd, motor_rev, fast, busy} <= drive(PARK, mode_q[1]);
            end
          end else if (timer == TIMEOUT_LAST) begin
            state <= FAULT;
            timer <= '0;
            {motor_fwd, motor_rev, fast, busy} <= 4'b0000;
            fault <= 1'b1;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        DWELL: begin
          if (!wipe_req) begin
            state <= PARK;
            timer <= '0;
            {motor_fwd, motor_rev, fast, busy} <= drive(PARK, mode_q[1]);
          end else if (timer == DWELL_LAST) begin
            timer <= '0;
            if (park_sw) begin
              state  <= OUT;
              mode_q <= mode;
              {motor_fwd, motor_rev, fast, busy} <= drive(OUT, mode[1]);
            end else begin
              state <= PARK;
              {motor_fwd, motor_rev, fast, busy} <= drive(PARK, mode_q[1]);
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wiper_motor_seq.sv
// Bench for wiper_motor_seq: a behavioural arm drives the position switches and
// a queue of expected sweep counts is checked at every return to park.
module tb_wiper_motor_seq;

  localparam int TIMEOUT   = 20;
  localparam int INT_DELAY = 10;
  localparam int CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wipe_req = 1'b0;
  logic [1:0]       mode = 2'b01;
  logic             park_sw = 1'b1;
  logic             end_sw = 1'b0;
  logic             motor_fwd, motor_rev, fast, busy, fault;
  logic [CNT_W-1:0] sweep_cnt;

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic last_fwd = 1'b0, last_rev = 1'b0, fwd_rise = 1'b0, rev_fall = 1'b0;
  logic exp_fast = 1'b0, fast_bad = 1'b0;
  int   fwd_cycles = 0, rev_cycles = 0;

  logic model_en = 1'b1, no_end = 1'b0;
  int   end_at = 5;
  int   fcnt = 0, rcnt = 0;

  wiper_motor_seq #(.TIMEOUT(TIMEOUT), .INT_DELAY(INT_DELAY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wipe_req(wipe_req), .mode(mode),
    .park_sw(park_sw), .end_sw(end_sw),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev), .fast(fast),
    .busy(busy), .sweep_cnt(sweep_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  // Arm model: far end reached end_at cycles into the out stroke, park 5 cycles into the return
  initial begin
    forever begin
      @(negedge clk);
      if (model_en) begin
        if (motor_fwd) begin
          fcnt++;
          park_sw = 1'b0;
          if (fcnt >= end_at && !no_end) end_sw = 1'b1;
        end else begin
          fcnt = 0;
        end
        if (motor_rev) begin
          rcnt++;
          end_sw = 1'b0;
          if (rcnt >= 5) park_sw = 1'b1;
        end else begin
          rcnt = 0;
        end
      end
    end
  end

  task automatic step();
    last_fwd = motor_fwd;
    last_rev = motor_rev;
    @(negedge clk);
    fwd_rise = motor_fwd && !last_fwd;
    rev_fall = !motor_rev && last_rev;
    if (motor_fwd) fwd_cycles++;
    if (motor_rev) rev_cycles++;
    if ((motor_fwd || motor_rev) && fast !== exp_fast) fast_bad = 1'b1;
    if (fwd_rise) begin
      exp_cnt = exp_cnt + CNT_ONE;
      exp_q.push_back(exp_cnt);
    end
  endtask

  task automatic pop_exp(output logic [CNT_W-1:0] v);
    if (exp_q.size() == 0) v = 'x;
    else v = exp_q.pop_front();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  task automatic wait_return(input int budget, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rev_fall) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic count_idle(input int budget, output int gap);
    gap = 1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (motor_fwd) break;
      gap++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    checks++;
    if ({motor_fwd, motor_rev, fast, busy, fault} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, expected 00000", {motor_fwd, motor_rev, fast, busy, fault});
    end
    checks++;
    if (sweep_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d, expected 0", sweep_cnt);
    end
  endtask

  task automatic test_low_single();
    logic to;
    logic [CNT_W-1:0] e;
    mode = 2'b01; exp_fast = 1'b0; fast_bad = 1'b0;
    fwd_cycles = 0; rev_cycles = 0;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    checks++;
    if (motor_fwd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL low_fwd_latency: got %b, expected 1", motor_fwd);
    end
    wait_return(60, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL low_return: got timeout, expected return to park"); end
    pop_exp(e);
    checks++;
    if (sweep_cnt !== e) begin errors++; $display("[TB] FAIL low_count: got %0d, expected %0d", sweep_cnt, e); end
    checks++;
    if (fwd_cycles !== 5 || rev_cycles !== 5) begin
      errors++;
      $display("[TB] FAIL low_stroke_len: got fwd %0d rev %0d, expected 5 and 5", fwd_cycles, rev_cycles);
    end
    checks++;
    if (fast_bad !== 1'b0) begin errors++; $display("[TB] FAIL low_fast: got fast=1 while sweeping, expected 0"); end
    step();
    checks++;
    if ({motor_fwd, motor_rev, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL low_parked: got %b, expected 000", {motor_fwd, motor_rev, busy});
    end
  endtask

  task automatic test_high_continuous();
    logic to;
    logic [CNT_W-1:0] e;
    int gap;
    mode = 2'b10; exp_fast = 1'b1; fast_bad = 1'b0;
    wipe_req = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_return(60, to);
      checks++;
      if (to) begin errors++; $display("[TB] FAIL high_return%0d: got timeout, expected return", s); end
      pop_exp(e);
      checks++;
      if (sweep_cnt !== e) begin errors++; $display("[TB] FAIL high_count%0d: got %0d, expected %0d", s, sweep_cnt, e); end
      if (s < 2) begin
        count_idle(30, gap);
        checks++;
        if (gap !== 1) begin errors++; $display("[TB] FAIL high_gap%0d: got %0d, expected 1", s, gap); end
      end else begin
        wipe_req = 1'b0;
      end
    end
    checks++;
    if (fast_bad !== 1'b0) begin errors++; $display("[TB] FAIL high_fast: got fast=0 while sweeping, expected 1"); end
    repeat (3) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL high_stop: got busy %b, expected 0", busy); end
  endtask

  task automatic test_intermittent();
    logic to;
    logic [CNT_W-1:0] e;
    int gap;
    mode = 2'b00; exp_fast = 1'b0;
    wipe_req = 1'b1;
    wait_return(60, to);
    pop_exp(e);
    checks++;
    if (to || sweep_cnt !== e) begin errors++; $display("[TB] FAIL int_count1: got %0d, expected %0d", sweep_cnt, e); end
    count_idle(40, gap);
    checks++;
    if (gap !== INT_DELAY) begin errors++; $display("[TB] FAIL int_dwell: got %0d, expected %0d", gap, INT_DELAY); end
    wait_return(60, to);
    pop_exp(e);
    checks++;
    if (to || sweep_cnt !== e) begin errors++; $display("[TB] FAIL int_count2: got %0d, expected %0d", sweep_cnt, e); end
    repeat (3) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL int_dwell_busy: got %b, expected 1", busy); end
    wipe_req = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL int_release: got busy %b, expected 0", busy); end
    fwd_cycles = 0;
    repeat (15) step();
    checks++;
    if (fwd_cycles !== 0) begin errors++; $display("[TB] FAIL int_no_restart: got %0d fwd cycles, expected 0", fwd_cycles); end
  endtask

  task automatic test_mid_release();
    logic to;
    logic [CNT_W-1:0] e;
    mode = 2'b01; exp_fast = 1'b0;
    wipe_req = 1'b1;
    step();
    step();
    wipe_req = 1'b0;
    rev_cycles = 0;
    wait_return(60, to);
    checks++;
    if (to || rev_cycles !== 5) begin errors++; $display("[TB] FAIL mid_complete: got rev %0d, expected 5", rev_cycles); end
    pop_exp(e);
    checks++;
    if (sweep_cnt !== e) begin errors++; $display("[TB] FAIL mid_count: got %0d, expected %0d", sweep_cnt, e); end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_parked: got busy %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid_out();
    logic to;
    mode = 2'b01;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (motor_fwd !== 1'b0 || sweep_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got fwd %b cnt %0d, expected 0 and 0", motor_fwd, sweep_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    // Arm left off park: a request re-parks it without counting
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    checks++;
    if (motor_rev !== 1'b1 || motor_fwd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL repark_dir: got fwd %b rev %b, expected 0 1", motor_fwd, motor_rev);
    end
    wait_return(40, to);
    checks++;
    if (to || sweep_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL repark_count: got %0d, expected %0d", sweep_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    logic [CNT_W-1:0] held;
    logic seen;
    held = exp_cnt;
    mode = 2'b01; no_end = 1'b1;
    fwd_cycles = 0; seen = 1'b0;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (fault === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    checks++;
    if (!seen || fwd_cycles !== TIMEOUT) begin
      errors++;
      $display("[TB] FAIL timeout_fault: got fault %b after %0d fwd cycles, expected 1 after %0d", fault, fwd_cycles, TIMEOUT);
    end
    exp_q.delete();
    exp_cnt = held;
    wipe_req = 1'b1;
    repeat (10) step();
    checks++;
    if ({fault, motor_fwd, motor_rev, busy} !== 4'b1000 || sweep_cnt !== held) begin
      errors++;
      $display("[TB] FAIL timeout_hold: got %b cnt %0d, expected 1000 cnt %0d", {fault, motor_fwd, motor_rev, busy}, sweep_cnt, held);
    end
    wipe_req = 1'b0;
    no_end = 1'b0;
    apply_reset();
    step();
    checks++;
    if (fault !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %b, expected 0", fault); end
    park_sw = 1'b1;
  endtask

  task automatic test_contradiction();
    logic seen;
    mode = 2'b01; seen = 1'b0;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (motor_rev === 1'b1) begin seen = 1'b1; break; end
    end
    model_en = 1'b0;
    park_sw = 1'b1;
    end_sw = 1'b1;
    step();
    checks++;
    if (!seen || {fault, motor_fwd, motor_rev, busy} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL contradiction: got %b, expected 1000", {fault, motor_fwd, motor_rev, busy});
    end
    end_sw = 1'b0;
    model_en = 1'b1;
    apply_reset();
    step();
  endtask

  task automatic test_switch_wins();
    logic to;
    logic [CNT_W-1:0] e;
    mode = 2'b01; exp_fast = 1'b0;
    end_at = TIMEOUT;
    fwd_cycles = 0;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    wait_return(80, to);
    checks++;
    if (to || fault !== 1'b0 || fwd_cycles !== TIMEOUT) begin
      errors++;
      $display("[TB] FAIL switch_wins: got fault %b fwd %0d, expected 0 and %0d", fault, fwd_cycles, TIMEOUT);
    end
    pop_exp(e);
    checks++;
    if (sweep_cnt !== e) begin errors++; $display("[TB] FAIL switch_wins_count: got %0d, expected %0d", sweep_cnt, e); end
    end_at = 5;
  endtask

  task automatic test_wrap();
    logic to;
    logic [CNT_W-1:0] e;
    apply_reset();
    step();
    mode = 2'b10; exp_fast = 1'b1; fast_bad = 1'b0;
    wipe_req = 1'b1;
    for (int s = 0; s < 256; s++) begin
      wait_return(60, to);
      if (to) begin
        checks++;
        errors++;
        $display("[TB] FAIL wrap_return%0d: got timeout, expected return", s);
        break;
      end
      if (s == 255) wipe_req = 1'b0;
      pop_exp(e);
      checks++;
      if (sweep_cnt !== e) begin errors++; $display("[TB] FAIL wrap_count%0d: got %0d, expected %0d", s, sweep_cnt, e); end
    end
    checks++;
    if (sweep_cnt !== '0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d, expected 0", sweep_cnt); end
    checks++;
    if (fast_bad !== 1'b0) begin errors++; $display("[TB] FAIL wrap_fast: got fast=0 while sweeping, expected 1"); end
  endtask

  initial begin
    test_reset();
    test_low_single();
    test_high_continuous();
    test_intermittent();
    test_mid_release();
    test_reset_mid_out();
    test_timeout();
    test_contradiction();
    test_switch_wins();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
